// File: rtl/pipeline_pkg.sv
// Shared constants and fetch FSM encoding for the 5-stage RV32I pipeline.
package pipeline_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int          XLEN      = pipeline_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  localparam logic [XLEN-1:0] PC_INC  = XLEN'(32'd4);
  localparam logic [XLEN-1:0] PC_ZERO = {XLEN{1'b0}};

  // IF/ID register update with flush > stall > load > bubble priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc       <= PC_ZERO;
      pc_plus4 <= PC_ZERO;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc       <= PC_ZERO;
      pc_plus4 <= PC_ZERO;
      valid    <= 1'b0;
    end else if (stall) begin
      instr    <= instr;
      pc       <= pc;
      pc_plus4 <= pc_plus4;
      valid    <= valid;
    end else if (load) begin
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc + PC_INC;
      valid    <= 1'b1;
    end else begin
      instr    <= NOP_INSTR;
      pc       <= PC_ZERO;
      pc_plus4 <= PC_ZERO;
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns PCF, keeps one imem request in flight, and buffers a word
// returned while decode is stalled before handing it to the IF/ID register.
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN      = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = pipeline_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
);

  localparam logic [XLEN-1:0] PC_INC   = XLEN'(32'd4);
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(32'd3);
  localparam logic [XLEN-1:0] PC_ZERO  = {XLEN{1'b0}};

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [XLEN-1:0] pcf_r;
  logic [XLEN-1:0] pc_inflight_r;
  logic            hold_valid_r;
  logic [31:0]     hold_instr_r;
  logic [XLEN-1:0] hold_pc_r;
  logic            req_fire_s;
  logic            resp_keep_s;
  logic            ifid_load_s;
  logic [31:0]     ifid_instr_s;
  logic [XLEN-1:0] ifid_pc_s;

  // Requests are withheld during reset so nothing is issued before PCF is valid
  assign imem_req_valid = rst_n && (state_r == IDLE) && !hold_valid_r && !StallF && !PCSrcE;
  assign imem_req_addr  = pcf_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign resp_keep_s    = imem_resp_valid && (state_r == WAIT) && !PCSrcE;
  assign FetchBusy      = (state_r != IDLE);

  // Fetch FSM next-state: a redirect with no response yet must discard the late word
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_fire_s) state_nxt_s = WAIT;
        else            state_nxt_s = IDLE;
      end
      WAIT: begin
        if (imem_resp_valid) state_nxt_s = IDLE;
        else if (PCSrcE)     state_nxt_s = DRAIN;
        else                 state_nxt_s = WAIT;
      end
      DRAIN: begin
        if (imem_resp_valid) state_nxt_s = IDLE;
        else                 state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, PCF and the PC of the in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pcf_r         <= RESET_PC;
      pc_inflight_r <= PC_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if (PCSrcE)          pcf_r <= PCTargetE & PC_ALIGN;
      else if (req_fire_s) pcf_r <= pcf_r + PC_INC;
      else                 pcf_r <= pcf_r;
      if (req_fire_s) pc_inflight_r <= pcf_r;
      else            pc_inflight_r <= pc_inflight_r;
    end
  end

  // Hold buffer: filled while decode stalls, drained into IF/ID, untouched by FlushD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
      hold_instr_r <= NOP_INSTR;
      hold_pc_r    <= PC_ZERO;
    end else if (PCSrcE) begin
      hold_valid_r <= 1'b0;
    end else if (resp_keep_s && StallD) begin
      hold_valid_r <= 1'b1;
      hold_instr_r <= imem_resp_data;
      hold_pc_r    <= pc_inflight_r;
    end else if (hold_valid_r && !StallD && !FlushD) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  // IF/ID source select: the buffered word is older than any live response
  always_comb begin
    ifid_load_s = hold_valid_r || resp_keep_s;
    if (hold_valid_r) begin
      ifid_instr_s = hold_instr_r;
      ifid_pc_s    = hold_pc_r;
    end else begin
      ifid_instr_s = imem_resp_data;
      ifid_pc_s    = pc_inflight_r;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (StallD),
    .flush      (FlushD),
    .load       (ifid_load_s),
    .load_instr (ifid_instr_s),
    .load_pc    (ifid_pc_s),
    .instr      (InstrD),
    .pc         (PCD),
    .pc_plus4   (PCPlus4D),
    .valid      (ValidD)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: each task drives one scenario and checks inline.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stallf;
  logic        stalld;
  logic        flushd;
  logic        pcsrce;
  logic [31:0] pctargete;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        fetch_busy;

  int checks;
  int errors;

  if_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .StallF          (stallf),
    .StallD          (stalld),
    .FlushD          (flushd),
    .PCSrcE          (pcsrce),
    .PCTargetE       (pctargete),
    .imem_req_valid  (req_valid),
    .imem_req_ready  (req_ready),
    .imem_req_addr   (req_addr),
    .imem_resp_valid (resp_valid),
    .imem_resp_data  (resp_data),
    .InstrD          (instr_d),
    .PCD             (pc_d),
    .PCPlus4D        (pcplus4_d),
    .ValidD          (valid_d),
    .FetchBusy       (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stallf = 1'b0; stalld = 1'b0; flushd = 1'b0; pcsrce = 1'b0;
    pctargete = 32'h0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
    tick(); tick();
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_d, NOP); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pcd got %h exp %h", pc_d, 32'h0); end
    checks++; if (pcplus4_d !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got %h exp %h", pcplus4_d, 32'h0); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_d); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", fetch_busy); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid got %b exp 1", req_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL basic_req_addr got %h exp %h", req_addr, 32'h0); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", fetch_busy); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL basic_no_second_req got %b exp 0", req_valid); end
    resp_valid = 1'b1; resp_data = 32'h0050_0093;
    tick();
    resp_valid = 1'b0;
    checks++; if (instr_d !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h exp %h", instr_d, 32'h0050_0093); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL basic_pcd got %h exp %h", pc_d, 32'h0); end
    checks++; if (pcplus4_d !== 32'h4) begin errors++; $display("FAIL basic_pcp4 got %h exp %h", pcplus4_d, 32'h4); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid_d); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", fetch_busy); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL basic_next_req got %b exp 1", req_valid); end
    checks++; if (req_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got %h exp %h", req_addr, 32'h4); end
  endtask

  task automatic test_stall_hold();
    stalld = 1'b1; req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h0020_8133;
    tick();
    resp_valid = 1'b0;
    checks++; if (instr_d !== 32'h0050_0093) begin errors++; $display("FAIL hold_ifid_instr got %h exp %h", instr_d, 32'h0050_0093); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL hold_ifid_pc got %h exp %h", pc_d, 32'h0); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hold_block_req got %b exp 0", req_valid); end
    req_ready = 1'b1;
    tick();
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL hold_no_fire got %b exp 0", fetch_busy); end
    stalld = 1'b0;
    tick();
    req_ready = 1'b0;
    checks++; if (instr_d !== 32'h0020_8133) begin errors++; $display("FAIL hold_release_instr got %h exp %h", instr_d, 32'h0020_8133); end
    checks++; if (pc_d !== 32'h4) begin errors++; $display("FAIL hold_release_pcd got %h exp %h", pc_d, 32'h4); end
    checks++; if (pcplus4_d !== 32'h8) begin errors++; $display("FAIL hold_release_pcp4 got %h exp %h", pcplus4_d, 32'h8); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL hold_release_valid got %b exp 1", valid_d); end
    checks++; if (req_addr !== 32'h8) begin errors++; $display("FAIL hold_next_addr got %h exp %h", req_addr, 32'h8); end
  endtask

  task automatic test_redirect();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    // low bits of the target are set on purpose; PCF must come out word-aligned
    pcsrce = 1'b1; pctargete = 32'h0000_0103;
    tick();
    pcsrce = 1'b0;
    #1;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL redir_drain_busy got %b exp 1", fetch_busy); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL redir_drain_req got %b exp 0", req_valid); end
    checks++; if (req_addr !== 32'h100) begin errors++; $display("FAIL redir_pcf got %h exp %h", req_addr, 32'h100); end
    tick();
    resp_valid = 1'b1; resp_data = 32'h00a0_0093;
    tick();
    resp_valid = 1'b0;
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL redir_dropped_valid got %b exp 0", valid_d); end
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL redir_dropped_instr got %h exp %h", instr_d, NOP); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL redir_idle got %b exp 0", fetch_busy); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL redir_req got %b exp 1", req_valid); end
    checks++; if (req_addr !== 32'h100) begin errors++; $display("FAIL redir_req_addr got %h exp %h", req_addr, 32'h100); end
  endtask

  task automatic test_flush();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0030_0113;
    tick();
    resp_valid = 1'b0;
    checks++; if (pc_d !== 32'h100) begin errors++; $display("FAIL flush_pre_pcd got %h exp %h", pc_d, 32'h100); end
    stalld = 1'b1; req_ready = 1'b1;
    tick();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0040_0193;
    tick();
    resp_valid = 1'b0;
    checks++; if (instr_d !== 32'h0030_0113) begin errors++; $display("FAIL flush_pre_instr got %h exp %h", instr_d, 32'h0030_0113); end
    flushd = 1'b1;
    tick();
    flushd = 1'b0;
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL flush_instr got %h exp %h", instr_d, NOP); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", valid_d); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL flush_pcd got %h exp %h", pc_d, 32'h0); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_kept got %b exp 0", req_valid); end
    stalld = 1'b0;
    tick();
    checks++; if (instr_d !== 32'h0040_0193) begin errors++; $display("FAIL flush_post_instr got %h exp %h", instr_d, 32'h0040_0193); end
    checks++; if (pc_d !== 32'h104) begin errors++; $display("FAIL flush_post_pcd got %h exp %h", pc_d, 32'h104); end
    checks++; if (pcplus4_d !== 32'h108) begin errors++; $display("FAIL flush_post_pcp4 got %h exp %h", pcplus4_d, 32'h108); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL flush_post_valid got %b exp 1", valid_d); end
  endtask

  task automatic test_stallf();
    stallf = 1'b1; req_ready = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL stallf_req got %b exp 0", req_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL stallf_req_c%0d got %b exp 0", i, req_valid); end
      checks++; if (req_addr !== 32'h108) begin errors++; $display("FAIL stallf_pcf_c%0d got %h exp %h", i, req_addr, 32'h108); end
      checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL stallf_busy_c%0d got %b exp 0", i, fetch_busy); end
    end
    stallf = 1'b0; req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL notready_req_c%0d got %b exp 1", i, req_valid); end
      checks++; if (req_addr !== 32'h108) begin errors++; $display("FAIL notready_addr_c%0d got %h exp %h", i, req_addr, 32'h108); end
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL stallf_fire_busy got %b exp 1", fetch_busy); end
    checks++; if (req_addr !== 32'h10c) begin errors++; $display("FAIL stallf_fire_pcf got %h exp %h", req_addr, 32'h10c); end
  endtask

  task automatic test_reset_mid_wait();
    resp_valid = 1'b1; resp_data = 32'h0060_0213;
    tick();
    resp_valid = 1'b0; stalld = 1'b1; req_ready = 1'b1;
    tick();
    req_ready = 1'b0; stalld = 1'b0;
    checks++; if (instr_d !== 32'h0060_0213) begin errors++; $display("FAIL rstw_pre_instr got %h exp %h", instr_d, 32'h0060_0213); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL rstw_pre_busy got %b exp 1", fetch_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL rstw_instr got %h exp %h", instr_d, NOP); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rstw_valid got %b exp 0", valid_d); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL rstw_pcd got %h exp %h", pc_d, 32'h0); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got %b exp 0", fetch_busy); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rstw_req got %b exp 0", req_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL rstw_addr got %h exp %h", req_addr, 32'h0); end
    tick();
    rst_n = 1'b1; resp_valid = 1'b1; resp_data = 32'h0bad_0000;
    tick();
    resp_valid = 1'b0;
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rstw_stale_valid got %b exp 0", valid_d); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rstw_stale_busy got %b exp 0", fetch_busy); end
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rstw_first_req got %b exp 1", req_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL rstw_first_addr got %h exp %h", req_addr, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_addr !== 32'(i * 4)) begin errors++; $display("FAIL b2b_addr_%0d got %h exp %h", i, req_addr, 32'(i * 4)); end
      tick();
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_%0d got %b exp 0", i, req_valid); end
      resp_valid = 1'b1; resp_data = words[i];
      tick();
      resp_valid = 1'b0;
      checks++; if (instr_d !== words[i]) begin errors++; $display("FAIL b2b_instr_%0d got %h exp %h", i, instr_d, words[i]); end
      checks++; if (pc_d !== 32'(i * 4)) begin errors++; $display("FAIL b2b_pcd_%0d got %h exp %h", i, pc_d, 32'(i * 4)); end
      checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL b2b_reissue_%0d got %b exp 1", i, req_valid); end
    end
    req_ready = 1'b0;
  endtask

  task automatic test_wrap();
    pcsrce = 1'b1; pctargete = 32'hffff_ffff;
    tick();
    pcsrce = 1'b0;
    #1;
    checks++; if (req_addr !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_target got %h exp %h", req_addr, 32'hffff_fffc); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL wrap_pcf got %h exp %h", req_addr, 32'h0); end
    resp_valid = 1'b1; resp_data = 32'h0010_0073;
    tick();
    resp_valid = 1'b0;
    checks++; if (pc_d !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_pcd got %h exp %h", pc_d, 32'hffff_fffc); end
    checks++; if (pcplus4_d !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got %h exp %h", pcplus4_d, 32'h0); end
    checks++; if (instr_d !== 32'h0010_0073) begin errors++; $display("FAIL wrap_instr got %h exp %h", instr_d, 32'h0010_0073); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall_hold();
    test_redirect();
    test_flush();
    test_stallf();
    test_reset_mid_wait();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
